pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Parametrised successor to the single-register program counter. It holds the PC, and on each write cycle it either increments, jumps, calls (pushing a return address onto an internal return-address stack) or returns (popping from that stack). It sits between the control FSM, which drives write enable and mode, and the memory-address path. It also exposes a precomputed PC+INC value and stack status and error flags.

Parameters:
WIDTH, 16, bit width of PC, target address and stack entries
STACK_DEPTH, 8, number of return-address entries (power of two, >= 2)
INC, 2, increment step in address units (byte-addressed 16-bit instructions)
RESET_VECTOR, 16'h0000, PC value loaded on reset

Ports:
CLK  input  1  system clock, rising-edge active
RST  input  1  asynchronous, active-high reset
input_PCU_PCWrite  input  1  PC update enable for this cycle
input_PCU_mode  input  2  00 INC, 01 JUMP, 10 CALL, 11 RET
input_PCU_newPC  input  WIDTH  target address for JUMP/CALL
input_PCU_errClear  input  1  clears sticky error flags
output_PC  output  WIDTH  current PC (registered)
output_PCplus  output  WIDTH  output_PC + INC (combinational from register)
output_stackFull  output  1  stack holds STACK_DEPTH entries
output_stackEmpty  output  1  stack holds 0 entries
output_overflowErr  output  1  sticky: CALL attempted while full
output_underflowErr  output  1  sticky: RET attempted while empty

Behaviour:
- Reset (async, while RST=1): output_PC=RESET_VECTOR, stack count=0 (stackEmpty=1, stackFull=0), both error flags=0. Stack storage contents are not reset; they are don't-care until written. Reset mid-operation discards any pending update.
- All updates happen on the CLK rising edge with RST=0. New PC is visible one cycle after the enabling edge.
- PCWrite=0: PC, stack and count hold regardless of mode and newPC.
- PCWrite=1, INC: PC <= PC+INC, modulo 2^WIDTH (wraps at top, e.g. 16'hFFFE+2 -> 16'h0000).
- PCWrite=1, JUMP: PC <= newPC. Stack is untouched.
- PCWrite=1, CALL, not full: mem[count] <= PC+INC, count <= count+1, PC <= newPC.
- PCWrite=1, CALL, full: PC <= newPC, no push, count unchanged, overflowErr <= 1.
- PCWrite=1, RET, not empty: PC <= mem[count-1], count <= count-1.
- PCWrite=1, RET, empty: PC <= PC+INC (treated as INC), underflowErr <= 1.
- The count register is $clog2(STACK_DEPTH)+1 bits. full = (count==STACK_DEPTH). empty = (count==0). Both flags are decoded from the registered count.
- errClear=1 clears both error flags on the edge. If errClear and a new error event occur in the same cycle, the set wins (flag=1).
- output_PCplus always equals output_PC+INC mod 2^WIDTH, including after reset.
- No internal states other than PC, count, storage and flags. The mode decode is purely per-cycle.

Decomposition:
- Shared package pcu_pkg holds the mode encodings PCU_INC, PCU_JUMP, PCU_CALL and PCU_RET. The control FSM imports the same constants.
- One sub-module: pc_return_stack (parameters WIDTH and STACK_DEPTH). It has push/pop/push-data inputs and top/full/empty/count outputs, and ignores a push when full or a pop when empty. pc_unit owns the PC register, the mode mux and the error flags.

Test Plan:
- Assert RST mid-cycle with PC=16'h0040 and count=3 -> immediately PC=16'h0000, stackEmpty=1, errors=0, before any CLK edge.
- From PC=16'h0000, issue 3 INC cycles, then hold PCWrite=0 with mode=JUMP, newPC=16'h1234 -> PC goes 2, 4, 6 and then holds at 16'h0006.
- Starting at PC=16'h0010, CALL to 16'h0100, then CALL to 16'h0200, then RET, then RET -> PC sequence 0100, 0200, 0102, 0012; stackEmpty=1 at end.
- Issue 9 CALLs with STACK_DEPTH=8 -> stackFull=1 after the 8th; the 9th still jumps, overflowErr=1, and count stays 8. Then 8 RETs return addresses in LIFO order.
- With the stack empty at PC=16'h0020, RET -> PC=16'h0022, underflowErr=1. Next cycle, errClear=1 together with another empty RET -> flag stays 1. Following cycle, errClear alone -> flag 0.
- At PC=16'hFFFE, INC -> PC=16'h0000 and output_PCplus=16'h0002. At PC=16'hFFFE, CALL to 16'h0008, then RET -> PC=16'h0000.

Source files
------------

// File: rtl/pcu_pkg.sv
// Shared mode encodings for the program-counter unit.
// The control FSM imports the same constants so both sides agree on the decode.
package pcu_pkg;

    typedef logic [1:0] pcu_mode_t;

    localparam pcu_mode_t PCU_INC  = 2'b00;
    localparam pcu_mode_t PCU_JUMP = 2'b01;
    localparam pcu_mode_t PCU_CALL = 2'b10;
    localparam pcu_mode_t PCU_RET  = 2'b11;

endpackage

// File: rtl/pc_return_stack.sv
// Return-address stack for pc_unit.
// Pushes while full and pops while empty are silently ignored; the caller owns error reporting.
module pc_return_stack #(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 8
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             push,
    input  logic                             pop,
    input  logic [WIDTH-1:0]                 push_data,
    output logic [WIDTH-1:0]                 top,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(STACK_DEPTH):0]     count
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [WIDTH-1:0] mem [STACK_DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_dec;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(STACK_DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty && !push;
    assign count   = count_q;

    // count is one bit wider than the index so "full" is distinguishable from "empty"
    assign count_dec = count_q - CNT_W'(1);
    assign top       = mem[count_dec[IDX_W-1:0]];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
        end else if (do_push) begin
            count_q <= count_q + CNT_W'(1);
        end else if (do_pop) begin
            count_q <= count_dec;
        end
    end

    // Storage is not reset; entries only matter once they have been pushed.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[count_q[IDX_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with increment, jump, call/return via an internal return-address stack,
// precomputed PC+INC, stack status and sticky overflow/underflow flags.
module pc_unit
    import pcu_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter int               STACK_DEPTH  = 8,
    parameter int               INC          = 2,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             input_PCU_PCWrite,
    input  logic [1:0]       input_PCU_mode,
    input  logic [WIDTH-1:0] input_PCU_newPC,
    input  logic             input_PCU_errClear,
    output logic [WIDTH-1:0] output_PC,
    output logic [WIDTH-1:0] output_PCplus,
    output logic             output_stackFull,
    output logic             output_stackEmpty,
    output logic             output_overflowErr,
    output logic             output_underflowErr
);

    localparam int CNT_W = $clog2(STACK_DEPTH) + 1;

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_plus;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] stack_top;
    logic [CNT_W-1:0] stack_count;
    logic             stack_full;
    logic             stack_empty;
    logic             push;
    logic             pop;
    logic             overflow_set;
    logic             underflow_set;
    logic             overflow_q;
    logic             underflow_q;

    assign pc_plus = pc_q + WIDTH'(INC);

    pc_return_stack #(
        .WIDTH       (WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .CLK       (CLK),
        .RST       (RST),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus),
        .top       (stack_top),
        .full      (stack_full),
        .empty     (stack_empty),
        .count     (stack_count)
    );

    // Per-cycle mode decode; an empty RET degrades to INC but still flags underflow.
    always_comb begin
        pc_next       = pc_q;
        push          = 1'b0;
        pop           = 1'b0;
        overflow_set  = 1'b0;
        underflow_set = 1'b0;
        if (input_PCU_PCWrite) begin
            case (input_PCU_mode)
                PCU_INC: begin
                    pc_next = pc_plus;
                end
                PCU_JUMP: begin
                    pc_next = input_PCU_newPC;
                end
                PCU_CALL: begin
                    pc_next      = input_PCU_newPC;
                    push         = !stack_full;
                    overflow_set = stack_full;
                end
                PCU_RET: begin
                    if (stack_empty) begin
                        pc_next       = pc_plus;
                        underflow_set = 1'b1;
                    end else begin
                        pc_next = stack_top;
                        pop     = 1'b1;
                    end
                end
                default: begin
                    pc_next = pc_q;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_next;
        end
    end

    // A new error in the same cycle as errClear leaves the flag set.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (overflow_set) begin
                overflow_q <= 1'b1;
            end else if (input_PCU_errClear) begin
                overflow_q <= 1'b0;
            end
            if (underflow_set) begin
                underflow_q <= 1'b1;
            end else if (input_PCU_errClear) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign output_PC           = pc_q;
    assign output_PCplus       = pc_plus;
    assign output_stackFull    = (stack_count == CNT_W'(STACK_DEPTH));
    assign output_stackEmpty   = (stack_count == '0);
    assign output_overflowErr  = overflow_q;
    assign output_underflowErr = underflow_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed-vector bench for pc_unit with hand-computed expected PC and flag values.
module tb_pc_unit;
    import pcu_pkg::*;

    logic        CLK;
    logic        RST;
    logic        pc_write;
    logic [1:0]  mode;
    logic [15:0] new_pc;
    logic        err_clear;
    logic [15:0] pc;
    logic [15:0] pc_plus;
    logic        stack_full;
    logic        stack_empty;
    logic        overflow_err;
    logic        underflow_err;

    int checks;
    int errors;

    pc_unit #(
        .WIDTH        (16),
        .STACK_DEPTH  (8),
        .INC          (2),
        .RESET_VECTOR (16'h0000)
    ) dut (
        .CLK                 (CLK),
        .RST                 (RST),
        .input_PCU_PCWrite   (pc_write),
        .input_PCU_mode      (mode),
        .input_PCU_newPC     (new_pc),
        .input_PCU_errClear  (err_clear),
        .output_PC           (pc),
        .output_PCplus       (pc_plus),
        .output_stackFull    (stack_full),
        .output_stackEmpty   (stack_empty),
        .output_overflowErr  (overflow_err),
        .output_underflowErr (underflow_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle's inputs, let the rising edge take them, then settle on the falling edge.
    task automatic applyStimulus(input logic wr, input logic [1:0] m, input logic [15:0] npc, input logic clr);
        pc_write  = wr;
        mode      = m;
        new_pc    = npc;
        err_clear = clr;
        @(posedge CLK);
        @(negedge CLK);
        pc_write  = 1'b0;
        err_clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] ret_addr [$];
        logic [15:0] exp_pc;
        logic [15:0] target;

        checks    = 0;
        errors    = 0;
        RST       = 1'b1;
        pc_write  = 1'b0;
        mode      = PCU_INC;
        new_pc    = 16'h0000;
        err_clear = 1'b0;
        repeat (2) @(negedge CLK);

        checkOutput("rst_pc", pc, 16'h0000);
        checkOutput("rst_pcplus", pc_plus, 16'h0002);
        checkOutput("rst_empty", {15'b0, stack_empty}, 16'h0001);
        checkOutput("rst_full", {15'b0, stack_full}, 16'h0000);
        checkOutput("rst_ovf", {15'b0, overflow_err}, 16'h0000);
        checkOutput("rst_unf", {15'b0, underflow_err}, 16'h0000);
        RST = 1'b0;
        @(negedge CLK);

        // Build PC=0x0040 with three stacked returns and a pending underflow flag.
        applyStimulus(1'b1, PCU_RET, 16'h0000, 1'b0);
        checkOutput("pre_unf_pc", pc, 16'h0002);
        checkOutput("pre_unf_flag", {15'b0, underflow_err}, 16'h0001);
        applyStimulus(1'b1, PCU_CALL, 16'h0010, 1'b0);
        applyStimulus(1'b1, PCU_CALL, 16'h0020, 1'b0);
        applyStimulus(1'b1, PCU_CALL, 16'h0040, 1'b0);
        checkOutput("pre_rst_pc", pc, 16'h0040);
        checkOutput("pre_rst_empty", {15'b0, stack_empty}, 16'h0000);

        #2 RST = 1'b1;
        #1;
        checkOutput("async_rst_pc", pc, 16'h0000);
        checkOutput("async_rst_empty", {15'b0, stack_empty}, 16'h0001);
        checkOutput("async_rst_unf", {15'b0, underflow_err}, 16'h0000);
        checkOutput("async_rst_ovf", {15'b0, overflow_err}, 16'h0000);
        #1 RST = 1'b0;
        @(negedge CLK);

        applyStimulus(1'b1, PCU_INC, 16'h0000, 1'b0);
        checkOutput("inc1", pc, 16'h0002);
        applyStimulus(1'b1, PCU_INC, 16'h0000, 1'b0);
        checkOutput("inc2", pc, 16'h0004);
        applyStimulus(1'b1, PCU_INC, 16'h0000, 1'b0);
        checkOutput("inc3", pc, 16'h0006);
        checkOutput("inc3_plus", pc_plus, 16'h0008);
        applyStimulus(1'b0, PCU_JUMP, 16'h1234, 1'b0);
        applyStimulus(1'b0, PCU_JUMP, 16'h1234, 1'b0);
        checkOutput("hold", pc, 16'h0006);

        applyStimulus(1'b1, PCU_JUMP, 16'h0010, 1'b0);
        checkOutput("jump", pc, 16'h0010);
        checkOutput("jump_empty", {15'b0, stack_empty}, 16'h0001);
        applyStimulus(1'b1, PCU_CALL, 16'h0100, 1'b0);
        checkOutput("call1", pc, 16'h0100);
        applyStimulus(1'b1, PCU_CALL, 16'h0200, 1'b0);
        checkOutput("call2", pc, 16'h0200);
        applyStimulus(1'b1, PCU_RET, 16'h0000, 1'b0);
        checkOutput("ret1", pc, 16'h0102);
        applyStimulus(1'b1, PCU_RET, 16'h0000, 1'b0);
        checkOutput("ret2", pc, 16'h0012);
        checkOutput("ret2_empty", {15'b0, stack_empty}, 16'h0001);

        // Fill the stack from PC=0x0012; the ninth call must still jump but not push.
        exp_pc = 16'h0012;
        for (int i = 0; i < 9; i++) begin
            target = 16'h1000 + 16'(i * 16);
            if (i < 8) ret_addr.push_back(exp_pc + 16'h0002);
            applyStimulus(1'b1, PCU_CALL, target, 1'b0);
            exp_pc = target;
            checkOutput($sformatf("fill_pc%0d", i), pc, exp_pc);
            if (i == 6) checkOutput("fill7_notfull", {15'b0, stack_full}, 16'h0000);
            if (i == 7) begin
                checkOutput("fill8_full", {15'b0, stack_full}, 16'h0001);
                checkOutput("fill8_ovf", {15'b0, overflow_err}, 16'h0000);
            end
        end
        checkOutput("ovf_flag", {15'b0, overflow_err}, 16'h0001);
        checkOutput("ovf_still_full", {15'b0, stack_full}, 16'h0001);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, PCU_RET, 16'h0000, 1'b0);
            exp_pc = ret_addr.pop_back();
            checkOutput($sformatf("lifo_ret%0d", i), pc, exp_pc);
        end
        checkOutput("lifo_empty", {15'b0, stack_empty}, 16'h0001);
        checkOutput("lifo_last", pc, 16'h0014);
        applyStimulus(1'b0, PCU_INC, 16'h0000, 1'b1);
        checkOutput("ovf_cleared", {15'b0, overflow_err}, 16'h0000);

        applyStimulus(1'b1, PCU_JUMP, 16'h0020, 1'b0);
        applyStimulus(1'b1, PCU_RET, 16'h0000, 1'b0);
        checkOutput("unf_pc", pc, 16'h0022);
        checkOutput("unf_set", {15'b0, underflow_err}, 16'h0001);
        applyStimulus(1'b1, PCU_RET, 16'h0000, 1'b1);
        checkOutput("unf_clr_race_pc", pc, 16'h0024);
        checkOutput("unf_set_wins", {15'b0, underflow_err}, 16'h0001);
        applyStimulus(1'b0, PCU_RET, 16'h0000, 1'b1);
        checkOutput("unf_cleared", {15'b0, underflow_err}, 16'h0000);
        checkOutput("unf_clear_hold", pc, 16'h0024);

        applyStimulus(1'b1, PCU_JUMP, 16'hFFFE, 1'b0);
        checkOutput("top_plus", pc_plus, 16'h0000);
        applyStimulus(1'b1, PCU_INC, 16'h0000, 1'b0);
        checkOutput("wrap_pc", pc, 16'h0000);
        checkOutput("wrap_plus", pc_plus, 16'h0002);
        applyStimulus(1'b1, PCU_JUMP, 16'hFFFE, 1'b0);
        applyStimulus(1'b1, PCU_CALL, 16'h0008, 1'b0);
        checkOutput("wrap_call", pc, 16'h0008);
        applyStimulus(1'b1, PCU_RET, 16'h0000, 1'b0);
        checkOutput("wrap_ret", pc, 16'h0000);
        checkOutput("wrap_ret_empty", {15'b0, stack_empty}, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
